// File: rtl/sal_tlp_tx.sv
// rtl/sal_tlp_tx.sv - CH0 packet transmit engine: 3-DW header plus optional payload on a valid/ready stream
module sal_tlp_tx #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        header_fmt_i,
    input  logic [4:0]        header_type_i,
    input  logic [2:0]        header_tc_i,
    input  logic [8:0]        header_length_i,
    input  logic [15:0]       header_requestID_i,
    input  logic [15:0]       header_completID_i,
    input  logic              ch0_start_i,
    input  logic              pld_valid_i,
    input  logic [DATA_W-1:0] pld_data_i,
    output logic              pld_ready_o,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_sop_o,
    output logic              tx_eop_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_HDR2 = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;

    logic [2:0]       state;
    logic [2:0]       fmt_q;
    logic [4:0]       type_q;
    logic [2:0]       tc_q;
    logic [8:0]       len_q;
    logic [15:0]      req_q;
    logic [15:0]      cpl_q;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] tag_q;
    logic [9:0]       beat_cnt;
    logic             done_q;
    logic [7:0]       tag_field;
    logic             tx_hs;

    assign tag_field = 8'(tag_q);
    assign tx_hs     = tx_valid_o & tx_ready_i;
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = done_q;

    // Header beats come from latched fields; the payload phase is a pure pass-through.
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        tx_sop_o    = 1'b0;
        tx_eop_o    = 1'b0;
        pld_ready_o = 1'b0;
        case (state)
            ST_HDR0: begin
                tx_valid_o = 1'b1;
                tx_data_o  = {fmt_q, type_q, 1'b0, tc_q, 11'b0, len_q};
                tx_sop_o   = 1'b1;
            end
            ST_HDR1: begin
                tx_valid_o = 1'b1;
                tx_data_o  = {req_q, tag_field, 8'hFF};
            end
            ST_HDR2: begin
                tx_valid_o = 1'b1;
                tx_data_o  = {cpl_q, 16'h0000};
                tx_eop_o   = ~fmt_q[1];
            end
            ST_DATA: begin
                tx_valid_o  = pld_valid_i;
                tx_data_o   = pld_valid_i ? pld_data_i : '0;
                tx_eop_o    = pld_valid_i & (beat_cnt == 10'd1);
                pld_ready_o = tx_ready_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fmt_q    <= '0;
            type_q   <= '0;
            tc_q     <= '0;
            len_q    <= '0;
            req_q    <= '0;
            cpl_q    <= '0;
            tag_cnt  <= '0;
            tag_q    <= '0;
            beat_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= tx_hs & tx_eop_o;
            case (state)
                ST_IDLE: begin
                    if (ch0_start_i) begin
                        fmt_q   <= header_fmt_i;
                        type_q  <= header_type_i;
                        tc_q    <= header_tc_i;
                        len_q   <= header_length_i;
                        req_q   <= header_requestID_i;
                        cpl_q   <= header_completID_i;
                        tag_q   <= tag_cnt;
                        tag_cnt <= tag_cnt + 1'b1;
                        state   <= ST_HDR0;
                    end
                end
                ST_HDR0: if (tx_ready_i) state <= ST_HDR1;
                ST_HDR1: if (tx_ready_i) state <= ST_HDR2;
                ST_HDR2: begin
                    if (tx_ready_i) begin
                        if (fmt_q[1]) begin
                            // A zero length field encodes the maximum of 512 DWs.
                            beat_cnt <= (len_q == 9'd0) ? 10'd512 : {1'b0, len_q};
                            state    <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tx_hs) begin
                        beat_cnt <= beat_cnt - 10'd1;
                        if (beat_cnt == 10'd1) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sal_tlp_tx.sv
// tb/tb_sal_tlp_tx.sv - scoreboard bench for sal_tlp_tx
module tb_sal_tlp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  header_fmt_i = '0;
    logic [4:0]  header_type_i = '0;
    logic [2:0]  header_tc_i = '0;
    logic [8:0]  header_length_i = '0;
    logic [15:0] header_requestID_i = '0;
    logic [15:0] header_completID_i = '0;
    logic        ch0_start_i = 1'b0;
    logic        pld_valid_i;
    logic [31:0] pld_data_i;
    logic        pld_ready_o;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        tx_sop_o;
    logic        tx_eop_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    sal_tlp_tx #(.DATA_W(32), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .header_fmt_i(header_fmt_i), .header_type_i(header_type_i),
        .header_tc_i(header_tc_i), .header_length_i(header_length_i),
        .header_requestID_i(header_requestID_i), .header_completID_i(header_completID_i),
        .ch0_start_i(ch0_start_i),
        .pld_valid_i(pld_valid_i), .pld_data_i(pld_data_i), .pld_ready_o(pld_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_sop_o(tx_sop_o),
        .tx_eop_o(tx_eop_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        hdr;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] pld_q[$];
    beat_t       mon_b;
    int          checks = 0;
    int          failures = 0;
    int          cyc_cnt = 0;
    int          start_cnt = 0;
    int          pld_hs_cnt = 0;
    int          pld_rdy_cnt = 0;
    int          mode = 0;
    bit          mon_en = 0;
    bit          done_exp = 0;
    bit          pld_hs = 0;
    bit          prev_stall = 0;
    logic [33:0] prev_beat = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic s, input logic e, input logic h);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.hdr = h;
        exp_q.push_back(b);
    endtask

    task automatic flush();
        exp_q.delete();
        pld_q.delete();
        done_exp = 0;
        prev_stall = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {tx_valid_o, tx_sop_o, tx_eop_o, pld_ready_o, busy_o, done_o, tx_data_o}, 64'h0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        ch0_start_i = 1'b0;
        flush();
        repeat (2) cyc();
        chk_quiet("reset_outputs");
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic start_pkt(input logic [2:0] fmt, input logic [4:0] typ, input logic [2:0] tc,
                             input logic [8:0] len, input logic [15:0] req, input logic [15:0] cpl,
                             input logic [7:0] tag, input logic [31:0] pbase);
        int n;
        header_fmt_i = fmt; header_type_i = typ; header_tc_i = tc;
        header_length_i = len; header_requestID_i = req; header_completID_i = cpl;
        ch0_start_i = 1'b1;
        push_beat({fmt, typ, 1'b0, tc, 11'b0, len}, 1'b1, 1'b0, 1'b1);
        push_beat({req, tag, 8'hFF}, 1'b0, 1'b0, 1'b1);
        push_beat({cpl, 16'h0000}, 1'b0, ~fmt[1], 1'b1);
        if (fmt[1]) begin
            n = (len == 9'd0) ? 512 : int'(len);
            for (int i = 0; i < n; i++) begin
                push_beat(pbase + 32'(i), 1'b0, (i == n - 1), 1'b0);
                pld_q.push_back(pbase + 32'(i));
            end
        end
        start_cnt = cyc_cnt + 1;
        cyc();
        ch0_start_i = 1'b0;
        // Scramble header inputs: the packet in flight must not see them.
        header_fmt_i = 3'($urandom); header_type_i = 5'($urandom); header_tc_i = 3'($urandom);
        header_length_i = 9'($urandom); header_requestID_i = 16'($urandom);
        header_completID_i = 16'($urandom);
    endtask

    task automatic wait_done(input int bound, input int exp_lat);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc();
            if (done_o === 1'b1) seen = 1;
        end
        chk("done_seen", seen, 1);
        if (seen && exp_lat >= 0) chk("done_latency", cyc_cnt - start_cnt, exp_lat);
    endtask

    task automatic wait_pld(input int target, input int bound);
        bit hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            cyc();
            if (pld_hs_cnt >= target) hit = 1;
        end
        chk("payload_progress", hit, 1);
    endtask

    // Payload source and downstream ready driver.
    initial begin
        pld_valid_i = 1'b0;
        pld_data_i = '0;
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pld_hs && pld_q.size() != 0) void'(pld_q.pop_front());
            if (mode == 0) tx_ready_i = 1'b1;
            else tx_ready_i = ~tx_ready_i;
            if (pld_q.size() != 0 && (mode == 0 || $urandom_range(0, 3) != 0)) begin
                pld_valid_i = 1'b1;
                pld_data_i = pld_q[0];
            end else begin
                pld_valid_i = 1'b0;
                pld_data_i = $urandom;
            end
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_valid_o !== 1'b1) chk("idle_beat_zero", {tx_data_o, tx_sop_o, tx_eop_o}, 34'h0);
            chk("busy", busy_o, exp_q.size() != 0);
            chk("done", done_o, done_exp);
            if (pld_ready_o === 1'b1) begin
                pld_rdy_cnt++;
                chk("pld_ready_only_in_data", (exp_q.size() != 0) ? !exp_q[0].hdr : 1'b0, 1);
            end
            if (prev_stall) begin
                if (exp_q.size() != 0 && exp_q[0].hdr) chk("hdr_hold_valid", tx_valid_o, 1);
                if (tx_valid_o === 1'b1) chk("stall_stable", {tx_data_o, tx_sop_o, tx_eop_o}, prev_beat);
            end
            if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {tx_data_o, tx_sop_o, tx_eop_o}, 34'h0);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("beat", {tx_data_o, tx_sop_o, tx_eop_o}, {mon_b.data, mon_b.sop, mon_b.eop});
                end
            end
            done_exp = (tx_valid_o === 1'b1) && (tx_ready_i === 1'b1) && (tx_eop_o === 1'b1);
            pld_hs = (pld_valid_i === 1'b1) && (pld_ready_o === 1'b1);
            if (pld_hs) pld_hs_cnt++;
            prev_stall = (tx_valid_o === 1'b1) && (tx_ready_i !== 1'b1);
            prev_beat = {tx_data_o, tx_sop_o, tx_eop_o};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        mon_en = 1;

        // No-data packet
        pld_rdy_cnt = 0;
        start_pkt(3'b000, 5'h04, 3'd2, 9'd1, 16'h1234, 16'hABCD, 8'd0, 32'h0);
        wait_done(50, 3);
        chk("nodata_pld_ready_cnt", pld_rdy_cnt, 0);

        // Data packet, full throughput
        reset_dut();
        start_pkt(3'b010, 5'h00, 3'd0, 9'd4, 16'h5A5A, 16'hC3C3, 8'd0, 32'hA0);
        wait_done(50, 7);

        // Backpressure and payload gaps
        reset_dut();
        mode = 1;
        start_pkt(3'b010, 5'h00, 3'd0, 9'd4, 16'h5A5A, 16'hC3C3, 8'd0, 32'hA0);
        wait_done(300, -1);
        chk("bp_exp_empty", exp_q.size(), 0);
        chk("bp_pld_empty", pld_q.size(), 0);
        mode = 0;

        // Length 0 means 512 payload DWs
        reset_dut();
        start_pkt(3'b010, 5'h0A, 3'd7, 9'd0, 16'h0F0F, 16'hF0F0, 8'd0, 32'h1000);
        wait_done(600, 515);

        // Start while busy is ignored; start in done cycle is accepted
        reset_dut();
        start_pkt(3'b010, 5'h02, 3'd1, 9'd6, 16'h1111, 16'h2222, 8'd0, 32'hB0);
        wait_pld(pld_hs_cnt + 1, 20);
        header_fmt_i = 3'b000; header_type_i = 5'h1F; header_requestID_i = 16'hDEAD;
        ch0_start_i = 1'b1;
        cyc();
        ch0_start_i = 1'b0;
        wait_done(50, 9);
        start_pkt(3'b000, 5'h05, 3'd3, 9'd2, 16'h3333, 16'h4444, 8'd1, 32'h0);
        wait_done(50, 3);

        // Reset mid-packet, start coincident with reset ignored
        reset_dut();
        start_pkt(3'b010, 5'h06, 3'd0, 9'd8, 16'h7777, 16'h8888, 8'd0, 32'hC0);
        wait_pld(pld_hs_cnt + 2, 30);
        cyc();
        rst_n = 1'b0;
        ch0_start_i = 1'b1;
        flush();
        cyc();
        chk_quiet("mid_reset_outputs");
        rst_n = 1'b1;
        ch0_start_i = 1'b0;
        cyc();
        start_pkt(3'b000, 5'h04, 3'd2, 9'd1, 16'h9999, 16'hAAAA, 8'd0, 32'h0);
        wait_done(50, 3);

        cyc();
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_pld_empty", pld_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
